// File: rtl/mdu_multicycle.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers and single-cycle MTHI/MTLO.
// Optional exception-flush abort via the `cancel` port when MDU_CANCEL_EN is defined.
module mdu_multicycle #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             mt_en,
  input  logic [2:0]       mdu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef MDU_CANCEL_EN
  input  logic             cancel,
`endif
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  logic [0:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic             cancel_s;

`ifdef MDU_CANCEL_EN
  assign cancel_s = cancel;
`else
  assign cancel_s = 1'b0;
`endif

  logic [2*WIDTH-1:0] prod_s;
  logic               a_neg_s, b_neg_s;
  logic [WIDTH-1:0]   ua_s, ub_s, den_s, q_mag_s, r_mag_s, quo_s, rem_s;
  logic [WIDTH-1:0]   res_hi_s, res_lo_s;

  // Product: low 2*WIDTH bits of the extended operands give the exact signed/unsigned result.
  always_comb begin
    if (op_q == OP_MULT) begin
      prod_s = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
    end else begin
      prod_s = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    end
  end

  // Sign-magnitude division; the most-negative / -1 case falls out as quotient = most negative, remainder 0.
  always_comb begin
    a_neg_s = (op_q == OP_DIV) && a_q[WIDTH-1];
    b_neg_s = (op_q == OP_DIV) && b_q[WIDTH-1];
    ua_s    = a_neg_s ? (ZERO - a_q) : a_q;
    ub_s    = b_neg_s ? (ZERO - b_q) : b_q;
    den_s   = (b_q == ZERO) ? ONE : ub_s;
    q_mag_s = ua_s / den_s;
    r_mag_s = ua_s % den_s;
    quo_s   = (a_neg_s ^ b_neg_s) ? (ZERO - q_mag_s) : q_mag_s;
    rem_s   = a_neg_s ? (ZERO - r_mag_s) : r_mag_s;
  end

  // Result selection from the latched op.
  always_comb begin
    res_hi_s = hi_q;
    res_lo_s = lo_q;
    case (op_q)
      OP_MULT, OP_MULTU: begin
        res_hi_s = prod_s[2*WIDTH-1:WIDTH];
        res_lo_s = prod_s[WIDTH-1:0];
      end
      OP_DIV, OP_DIVU: begin
        if (b_q == ZERO) begin
          res_hi_s = a_q;
          res_lo_s = ONES;
        end else begin
          res_hi_s = rem_s;
          res_lo_s = quo_s;
        end
      end
      default: begin
        res_hi_s = hi_q;
        res_lo_s = lo_q;
      end
    endcase
  end

  // Next-state: launch/MT in IDLE, count down and commit atomically in RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (cancel_s) begin
          state_d = S_IDLE;
        end else if (start && (mdu_op <= OP_DIVU)) begin
          op_d    = mdu_op;
          a_d     = a;
          b_d     = b;
          cnt_d   = (mdu_op >= OP_DIV) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
          state_d = S_RUN;
        end else if (mt_en && !start) begin
          if (mdu_op == OP_MTHI) begin
            hi_d = a;
          end else if (mdu_op == OP_MTLO) begin
            lo_d = a;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (cancel_s) begin
          cnt_d   = {CW{1'b0}};
          state_d = S_IDLE;
        end else if (cnt_q <= CNT_ONE) begin
          cnt_d   = {CW{1'b0}};
          hi_d    = res_hi_s;
          lo_d    = res_lo_s;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = {CW{1'b0}};
      end
    endcase
  end

  // State and data registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= {CW{1'b0}};
      op_q    <= 3'd0;
      a_q     <= ZERO;
      b_q     <= ZERO;
      hi_q    <= ZERO;
      lo_q    <= ZERO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/mdu_multicycle.md
# mdu_multicycle

Parametrised multi-cycle multiply/divide unit with HI/LO registers for the E stage of the pipelined MIPS core. It executes MULT/MULTU/DIV/DIVU over a configurable number of cycles, handles MTHI/MTLO in a single cycle, and raises `busy` so the hazard unit can stall MDU instructions. HI and LO are exposed continuously for MFHI/MFLO forwarding.

## Interface
- `WIDTH`, 32, operand and HI/LO width; must be at least 2.
- `MULT_CYCLES`, 5, busy cycles for MULT/MULTU; must be at least 1.
- `DIV_CYCLES`, 10, busy cycles for DIV/DIVU; must be at least 1.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  launch MULT/MULTU/DIV/DIVU this cycle.
- `mt_en`  in  1  write HI or LO this cycle (MTHI/MTLO).
- `mdu_op`  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6 and 7 are no-op.
- `a`  in  WIDTH  rs operand (multiplicand or dividend; MT source).
- `b`  in  WIDTH  rt operand (multiplier or divisor).
- `cancel`  in  1  abort in-flight operation; present only with `MDU_CANCEL_EN`.
- `busy`  out  1  operation in flight.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- States: IDLE and RUN. A down-counter sized for max(MULT_CYCLES, DIV_CYCLES) plus 1 tracks progress.
- Reset (asynchronous, reset_n low):
  - state is IDLE, `busy`=0, `hi`=0, `lo`=0, counter=0.
  - Any in-flight result is discarded.
- IDLE, with `start`=1 and `mdu_op` in 0..3:
  - Latch `a`, `b` and the op.
  - Load the counter with MULT_CYCLES or DIV_CYCLES.
  - Go to RUN.
- IDLE, with `start`=1 and `mdu_op` outside 0..3: ignored.
- IDLE, with `mt_en`=1 and `start`=0:
  - op 4 sets `hi`←`a`; op 5 sets `lo`←`a`; other ops are ignored.
  - Counter and state are unchanged.
- `start` and `mt_en` both high: `start` wins and `mt_en` is dropped.
- RUN:
  - The counter decrements each cycle.
  - On the edge where it reaches 0, HI/LO are written with the result and the state returns to IDLE.
  - `start` and `mt_en` are ignored while in RUN; the hazard unit must stall them.
- Multiply: {hi,lo} = full 2·WIDTH-bit product. MULT is signed×signed; MULTU is unsigned×unsigned.
- Divide results:
  - `lo` = quotient, `hi` = remainder.
  - DIV is signed, with the quotient truncated toward zero and the remainder taking the dividend's sign. DIVU is unsigned.
- Divide by zero: `hi`=`a`, `lo`=all ones, for both signed and unsigned.
- Signed overflow (a = most negative, b = −1): `lo`=most negative, `hi`=0.
- The result is computed from the latched operands. Operand changes during RUN have no effect.
- HI/LO keep their old values for the whole of RUN. A new result commits atomically to both registers.

## Timing
- `start` sampled at edge 0 → `busy`=1 from after edge 0 through edge N, where N is MULT_CYCLES or DIV_CYCLES.
- New `hi`/`lo` become visible after edge N, in the same cycle `busy` returns to 0.
- `busy` is registered; it is not combinational from `start`. The hazard unit stalls on (`busy` | `start`) together with any MDU instruction in D.
- MTHI/MTLO: `hi`/`lo` update on the sampling edge and are visible the next cycle. No busy cycle.
- Back-to-back: a `start` in the first IDLE cycle after completion is accepted.
- Reset asserted mid-RUN: returns to IDLE immediately. HI/LO read 0, not the pending result.

## Configuration
- `MDU_CANCEL_EN` defined:
  - The `cancel` port exists.
  - `cancel`=1 during RUN → next edge returns to IDLE, `busy`=0, HI/LO keep their pre-start values.
  - `cancel` in IDLE drops any same-cycle `start` or `mt_en`.
  - Used for exception flush.
- Undefined: there is no `cancel` port. Every operation that starts runs to completion.

## Test plan
- Reset low → `busy`=0, `hi`=0, `lo`=0. Then MTHI a=0x1234 → `hi`=0x00001234 next cycle, `busy` stays 0.
- MULT with a=0xFFFFFFFE (−2), b=3, MULT_CYCLES=5 → `busy` high 5 cycles. Then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA. HI/LO unchanged while busy.
- MULTU with a=0xFFFFFFFF, b=2 → `hi`=0x00000001, `lo`=0xFFFFFFFE.
- Division cases:
  - DIV a=−7, b=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - DIV a=0x80000000, b=0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
  - DIVU a=5, b=0 → `hi`=5, `lo`=0xFFFFFFFF.
- `start` and MTLO asserted during RUN → both ignored, and the result matches the original op. `start` and `mt_en` in the same IDLE cycle → the multiply runs and LO is not written by the MTLO.
- With `MDU_CANCEL_EN`: start DIV, then `cancel` at cycle 3 → `busy`=0 next cycle, HI/LO keep their prior values. Separately, `reset_n` low mid-RUN → `busy`=0, HI/LO=0.
